// File: rtl/neuron_param_bank_if.sv
// Wishbone classic slave bundle for the neuron parameter bank.
// The host side uses the master modport, the bank uses the slave modport.
interface neuron_param_bank_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i,
        output wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
        input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/neuron_param_bank.sv
// Wishbone-mapped per-neuron parameter store with a scan FSM feeding the datapath.
// Optional macro NEG_THRESH_MIRROR_EN: negative threshold output mirrors -pos_thresh.
module neuron_param_bank #(
    parameter int          NUM_NEURONS     = 16,
    parameter int          NUM_AXONS       = 256,
    parameter int          LEAK_WIDTH      = 9,
    parameter int          WEIGHT_WIDTH    = 9,
    parameter int          THRESHOLD_WIDTH = 9,
    parameter int          POTENTIAL_WIDTH = 9,
    parameter int          NUM_RESET_MODES = 2,
    parameter logic [31:0] PARAM_BASE      = 32'h3000_0000,
    localparam int IW   = $clog2(NUM_NEURONS),
    localparam int RM_W = (NUM_RESET_MODES > 1) ? $clog2(NUM_RESET_MODES) : 1
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    neuron_param_bank_if.slave          wb,
    input  logic                        enable_calc_i,
    input  logic                        update_valid_i,
    input  logic [POTENTIAL_WIDTH-1:0]  new_potential_i,
    output logic                        param_valid_o,
    output logic [IW-1:0]               neuron_idx_o,
    output logic [NUM_AXONS-1:0]        connections_o,
    output logic [LEAK_WIDTH-1:0]       leak_o,
    output logic [WEIGHT_WIDTH-1:0]     weights_0_o,
    output logic [WEIGHT_WIDTH-1:0]     weights_1_o,
    output logic [THRESHOLD_WIDTH-1:0]  positive_threshold_o,
    output logic [THRESHOLD_WIDTH-1:0]  negative_threshold_o,
    output logic [POTENTIAL_WIDTH-1:0]  reset_potential_o,
    output logic [POTENTIAL_WIDTH-1:0]  current_potential_o,
    output logic [RM_W-1:0]             reset_mode_o,
    output logic                        busy_o,
    output logic                        scan_done_o
);
    localparam int CW    = NUM_AXONS / 32;
    localparam int SW    = $clog2(CW + 8);
    localparam int AW    = SW + IW;
    localparam int DEPTH = NUM_NEURONS << SW;
    localparam logic [SW:0]   NREAL = (SW + 1)'(CW + 8);
    localparam logic [SW-1:0] O_CP  = SW'(CW + 0);
    localparam logic [SW-1:0] O_RP  = SW'(CW + 1);
    localparam logic [SW-1:0] O_PT  = SW'(CW + 2);
    localparam logic [SW-1:0] O_NT  = SW'(CW + 3);
    localparam logic [SW-1:0] O_W0  = SW'(CW + 4);
    localparam logic [SW-1:0] O_W1  = SW'(CW + 5);
    localparam logic [SW-1:0] O_LK  = SW'(CW + 6);
    localparam logic [SW-1:0] O_RM  = SW'(CW + 7);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [31:0]   mem [DEPTH];
    logic [IW-1:0] idx_q;
    logic          wr_dropped_q;

    logic [29:0]   wa;
    logic [SW-1:0] wofs;
    logic [AW-1:0] maddr;
    logic          in_rec;
    logic          in_csr;
    logic          is_pad;
    logic          req;
    logic          wr;
    logic          rec_wr;
    logic          drop;
    logic          csr_wr;
    logic          start;
    logic          wb_upd;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          unused_ok;

    assign unused_ok = &{1'b0, wb.wbs_adr_i[1:0]};

    assign wa     = wb.wbs_adr_i[31:2] - PARAM_BASE[31:2];
    assign wofs   = wa[SW-1:0];
    assign maddr  = wa[AW-1:0];
    assign in_rec = wa < 30'(DEPTH);
    assign in_csr = wa == 30'(DEPTH);
    assign is_pad = {1'b0, wofs} >= NREAL;

    assign req    = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o;
    assign wr     = req & wb.wbs_we_i;
    assign rec_wr = wr & in_rec & ~is_pad & ~busy_o;
    assign drop   = wr & in_rec & busy_o;
    assign csr_wr = wr & in_csr & wb.wbs_sel_i[0];
    assign start  = enable_calc_i | (csr_wr & wb.wbs_dat_i[2]);
    assign wb_upd = (state_q == S_PRESENT) & update_valid_i;

    // Byte-lane merge of host write data onto the addressed word
    always_comb begin
        wdata = mem[maddr];
        for (int b = 0; b < 4; b++) begin
            if (wb.wbs_sel_i[b]) begin
                wdata[8*b +: 8] = wb.wbs_dat_i[8*b +: 8];
            end
        end
    end

    // Read mux: record words, pads as zero, CSR status, everything else zero
    always_comb begin
        rdata = '0;
        if (in_rec) begin
            if (!is_pad) begin
                rdata = mem[maddr];
            end
        end else if (in_csr) begin
            rdata = {30'd0, wr_dropped_q, busy_o};
        end
    end

    // Parameter storage: host writes when idle, potential writeback when scanning
    always_ff @(posedge wb_clk_i) begin
        if (rec_wr) begin
            mem[maddr] <= wdata;
        end else if (wb_upd) begin
            mem[{idx_q, O_CP}] <= {{(32 - POTENTIAL_WIDTH){new_potential_i[POTENTIAL_WIDTH-1]}},
                                   new_potential_i};
        end
    end

    // Wishbone ack/data with one wait state, plus the sticky dropped-write flag
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_dat_o <= '0;
            wr_dropped_q <= 1'b0;
        end else begin
            wb.wbs_ack_o <= req;
            if (req) begin
                wb.wbs_dat_o <= rdata;
            end
            if (drop) begin
                wr_dropped_q <= 1'b1;
            end else if (csr_wr && wb.wbs_dat_i[1]) begin
                wr_dropped_q <= 1'b0;
            end
        end
    end

    // Scan state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan next-state and status outputs
    always_comb begin
        state_d       = state_q;
        param_valid_o = 1'b0;
        busy_o        = 1'b1;
        scan_done_o   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                param_valid_o = 1'b1;
                if (update_valid_i) begin
                    state_d = (idx_q == IW'(NUM_NEURONS - 1)) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                scan_done_o = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Neuron index: cleared on start, advanced after each writeback
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            idx_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            idx_q <= '0;
        end else if (wb_upd && idx_q != IW'(NUM_NEURONS - 1)) begin
            idx_q <= idx_q + 1'b1;
        end
    end

    assign neuron_idx_o = idx_q;

    // Record fetch: register the indexed neuron's fields during LOAD
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            connections_o        <= '0;
            leak_o               <= '0;
            weights_0_o          <= '0;
            weights_1_o          <= '0;
            positive_threshold_o <= '0;
            negative_threshold_o <= '0;
            reset_potential_o    <= '0;
            current_potential_o  <= '0;
            reset_mode_o         <= '0;
        end else if (state_q == S_LOAD) begin
            for (int k = 0; k < CW; k++) begin
                connections_o[32*k +: 32] <= mem[{idx_q, SW'(k)}];
            end
            leak_o               <= mem[{idx_q, O_LK}][LEAK_WIDTH-1:0];
            weights_0_o          <= mem[{idx_q, O_W0}][WEIGHT_WIDTH-1:0];
            weights_1_o          <= mem[{idx_q, O_W1}][WEIGHT_WIDTH-1:0];
            positive_threshold_o <= mem[{idx_q, O_PT}][THRESHOLD_WIDTH-1:0];
`ifdef NEG_THRESH_MIRROR_EN
            negative_threshold_o <= -mem[{idx_q, O_PT}][THRESHOLD_WIDTH-1:0];
`else
            negative_threshold_o <= mem[{idx_q, O_NT}][THRESHOLD_WIDTH-1:0];
`endif
            reset_potential_o    <= mem[{idx_q, O_RP}][POTENTIAL_WIDTH-1:0];
            current_potential_o  <= mem[{idx_q, O_CP}][POTENTIAL_WIDTH-1:0];
            reset_mode_o         <= mem[{idx_q, O_RM}][RM_W-1:0];
        end
    end
endmodule

// File: tb/tb_neuron_param_bank.sv
// Testbench for neuron_param_bank: Wishbone load/readback and scan sequencing
// against a word-array model of the parameter map.
module tb_neuron_param_bank;
    localparam int N    = 16;
    localparam int NAX  = 256;
    localparam int CW   = NAX / 32;
    localparam int S    = 1 << $clog2(CW + 8);
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] CSR  = BASE + 32'(4 * N * S);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       upd = 1'b0;
    logic [8:0] npot = '0;
    logic       pv;
    logic [3:0] idx;
    logic [NAX-1:0] conn;
    logic [8:0] lk, w0, w1, pt, nt, rp, cp;
    logic [0:0] rm;
    logic       busy, done;

    int checks = 0;
    int failures = 0;
    logic [31:0] model [N*S];

    neuron_param_bank_if wbi ();

    neuron_param_bank dut (
        .wb_clk_i             (clk),
        .wb_rst_i             (rst),
        .wb                   (wbi),
        .enable_calc_i        (en),
        .update_valid_i       (upd),
        .new_potential_i      (npot),
        .param_valid_o        (pv),
        .neuron_idx_o         (idx),
        .connections_o        (conn),
        .leak_o               (lk),
        .weights_0_o          (w0),
        .weights_1_o          (w1),
        .positive_threshold_o (pt),
        .negative_threshold_o (nt),
        .reset_potential_o    (rp),
        .current_potential_o  (cp),
        .reset_mode_o         (rm),
        .busy_o               (busy),
        .scan_done_o          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr(input int n, input int w);
        return BASE + 32'(4 * (n * S + w));
    endfunction

    task automatic wb_xfer(input bit we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] rd);
        int lat;
        wbi.wbs_cyc_i = 1'b1;
        wbi.wbs_stb_i = 1'b1;
        wbi.wbs_we_i  = we;
        wbi.wbs_sel_i = sel;
        wbi.wbs_adr_i = a;
        wbi.wbs_dat_i = d;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (wbi.wbs_ack_o !== 1'b1 && lat < 8);
        check("ack_latency", 512'(lat), 512'(1));
        rd = wbi.wbs_dat_o;
        wbi.wbs_cyc_i = 1'b0;
        wbi.wbs_stb_i = 1'b0;
        wbi.wbs_we_i  = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", 512'(wbi.wbs_ack_o), 512'(0));
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] rd;
        wb_xfer(1'b1, a, d, sel, rd);
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] rd);
        wb_xfer(1'b0, a, 32'd0, 4'hF, rd);
    endtask

    // Host write that also updates the model when the bank is idle
    task automatic host_write(input int n, input int w, input logic [31:0] d);
        wb_wr(addr(n, w), d, 4'hF);
        model[n*S+w] = d;
    endtask

    task automatic load_all();
        for (int n = 0; n < N; n++) begin
            for (int w = 0; w < CW + 8; w++) begin
                host_write(n, w, $urandom);
            end
        end
        host_write(5, CW + 6, 32'h0000_01FD);
        host_write(5, CW + 4, 32'd7);
        host_write(5, CW + 2, 32'd100);
        host_write(6, CW + 2, 32'd20);
        host_write(6, CW + 3, 32'hFFFF_FFCE);
    endtask

    task automatic check_fields(input int n, input string tag);
        logic [NAX-1:0] c;
        logic [8:0] p;
        logic [8:0] ng;
        int b;
        b = n * S + CW;
        for (int k = 0; k < CW; k++) c[32*k +: 32] = model[n*S+k];
        p = model[b+2][8:0];
`ifdef NEG_THRESH_MIRROR_EN
        ng = 9'd0 - p;
`else
        ng = model[b+3][8:0];
`endif
        check({tag, "_idx"}, 512'(idx), 512'(n));
        check({tag, "_conn"}, 512'(conn), 512'(c));
        check({tag, "_cp"}, 512'(cp), 512'(model[b+0][8:0]));
        check({tag, "_rp"}, 512'(rp), 512'(model[b+1][8:0]));
        check({tag, "_pt"}, 512'(pt), 512'(p));
        check({tag, "_nt"}, 512'(nt), 512'(ng));
        check({tag, "_w0"}, 512'(w0), 512'(model[b+4][8:0]));
        check({tag, "_w1"}, 512'(w1), 512'(model[b+5][8:0]));
        check({tag, "_leak"}, 512'(lk), 512'(model[b+6][8:0]));
        check({tag, "_rm"}, 512'(rm), 512'(model[b+7][0]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_conn"}, 512'(conn), 512'(0));
        check({tag, "_outs"},
              512'({pv, idx, lk, w0, w1, pt, nt, rp, cp, rm, busy, done,
                    wbi.wbs_ack_o, wbi.wbs_dat_o}),
              512'(0));
    endtask

    // One scan; fixed mode answers 2 cycles into PRESENT with potential idx+1
    task automatic run_scan(input bit via_csr, input bit fixed, input int abort_at,
                            input bit drop_test, input bit busy_start);
        int cnt;
        int dly;
        int phases;
        logic [31:0] rd;
        logic [8:0] p;
        if (via_csr) begin
            wb_wr(CSR, 32'h4, 4'h1);
        end else begin
            en = 1'b1;
            @(posedge clk); #1;
            en = 1'b0;
        end
        phases = 0;
        for (int i = 0; i < N; i++) begin
            cnt = 0;
            while (pv !== 1'b1 && cnt < 10) begin
                @(posedge clk); #1;
                cnt++;
            end
            check("present_reached", 512'(pv), 512'(1));
            phases++;
            check("busy_in_scan", 512'(busy), 512'(1));
            check("no_early_done", 512'(done), 512'(0));
            check_fields(i, "present");
            if (i == 5) begin
                check("n5_leak", 512'(lk), 512'(9'h1FD));
                check("n5_w0", 512'(w0), 512'(9'd7));
                check("n5_pt", 512'(pt), 512'(9'd100));
            end
            if (i == 6) begin
`ifdef NEG_THRESH_MIRROR_EN
                check("n6_nt_mirror", 512'(nt), 512'(9'h1EC));
`else
                check("n6_nt_stored", 512'(nt), 512'(9'h1CE));
`endif
            end
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                check_all_zero("abort");
                @(posedge clk); #1;
                check_all_zero("abort_edge");
                rst = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(posedge clk); #1;
                    check("abort_no_done", 512'({done, busy, pv}), 512'(0));
                end
                return;
            end
            if (drop_test && i == 2) begin
                wb_wr(addr(0, CW + 6), 32'd5, 4'hF);
                wb_rd(CSR, rd);
                check("csr_dropped", 512'(rd), 512'(32'h3));
                wb_rd(addr(0, CW + 6), rd);
                check("drop_unchanged", 512'(rd), 512'(model[CW+6]));
                wb_wr(CSR, 32'h2, 4'h1);
                wb_rd(CSR, rd);
                check("csr_cleared", 512'(rd), 512'(32'h1));
            end
            if (busy_start && i == 3) begin
                en = 1'b1;
                @(posedge clk); #1;
                en = 1'b0;
            end
            dly = fixed ? 2 : int'($urandom_range(0, 3));
            repeat (dly) begin
                @(posedge clk); #1;
            end
            check("held_valid", 512'(pv), 512'(1));
            check_fields(i, "held");
            p = fixed ? 9'(i + 1) : 9'($urandom);
            upd = 1'b1;
            npot = p;
            @(posedge clk); #1;
            upd = 1'b0;
            model[i*S+CW] = 32'($signed(p));
        end
        check("present_phases", 512'(phases), 512'(N));
        cnt = 0;
        while (done !== 1'b1 && cnt < 4) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("scan_done", 512'(done), 512'(1));
        @(posedge clk); #1;
        check("done_one_cycle", 512'({done, busy}), 512'(0));
    endtask

    task automatic readback_all(input string tag);
        logic [31:0] rd;
        for (int n = 0; n < N; n++) begin
            for (int w = 0; w < CW + 8; w++) begin
                wb_rd(addr(n, w), rd);
                check(tag, 512'(rd), 512'(model[n*S+w]));
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        wbi.wbs_cyc_i = 1'b0;
        wbi.wbs_stb_i = 1'b0;
        wbi.wbs_we_i  = 1'b0;
        wbi.wbs_sel_i = '0;
        wbi.wbs_adr_i = '0;
        wbi.wbs_dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        wb_rd(CSR, rd);
        check("csr_idle", 512'(rd), 512'(0));
        wb_wr(addr(3, 0), 32'd0, 4'hF);
        wb_wr(addr(3, 0), 32'hDEAD_BEEF, 4'b0101);
        wb_rd(addr(3, 0), rd);
        check("byte_lanes", 512'(rd), 512'(32'h00AD_00EF));
        wb_wr(CSR + 32'd4, 32'hFFFF_FFFF, 4'hF);
        wb_rd(CSR + 32'd4, rd);
        check("unmapped_above", 512'(rd), 512'(0));
        wb_rd(BASE - 32'd4, rd);
        check("unmapped_below", 512'(rd), 512'(0));

        load_all();
        readback_all("load_rb");

        run_scan(1'b0, 1'b1, -1, 1'b1, 1'b0);
        for (int n = 0; n < N; n++) begin
            wb_rd(addr(n, CW), rd);
            check("pot_idx_plus1", 512'(rd), 512'(n + 1));
        end
        wb_rd(CSR, rd);
        check("csr_after_scan", 512'(rd), 512'(0));

        run_scan(1'b1, 1'b0, 7, 1'b0, 1'b0);

        load_all();
        run_scan(1'b0, 1'b0, -1, 1'b0, 1'b1);
        readback_all("scan_rb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
